// File: rtl/io_pkg.sv
// Types and default constants shared by the board input conditioning blocks.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } btn_state_t;

    localparam int unsigned DEBOUNCE_DEFAULT = 100000;
    localparam int unsigned SW_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton channel: 2-flop synchroniser, press/release debounce FSM,
// registered one-cycle press pulse and a debounced level.
module btn_debounce
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pulse,
    output logic level
);

    localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 s1;
    logic                 s2;
    btn_state_t           state;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            s1    <= btn_raw;
            s2    <= s1;
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= DEB_PRESS;
                        cnt   <= CNT_ONE;
                    end
                end
                DEB_PRESS: begin
                    if (!s2) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= HELD;
                        cnt   <= '0;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!s2) begin
                        state <= DEB_RELEASE;
                        cnt   <= CNT_ONE;
                    end
                end
                DEB_RELEASE: begin
                    if (s2) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        level = (state == HELD) || (state == DEB_RELEASE);
    end

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces the board pushbuttons and slide switches ahead
// of the memory-mapped IO peripheral.
module input_conditioner
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned SW_WIDTH        = SW_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btnL_raw,
    input  logic                btnR_raw,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic                buttonL,
    output logic                buttonR,
    output logic                btnL_level,
    output logic                btnR_level,
    output logic [SW_WIDTH-1:0] switch
);

    localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_l (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btnL_raw),
        .pulse   (buttonL),
        .level   (btnL_level)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_r (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btnR_raw),
        .pulse   (buttonR),
        .level   (btnR_level)
    );

    logic [SW_WIDTH-1:0]  sw_s1;
    logic [SW_WIDTH-1:0]  sw_s2;
    logic [SW_WIDTH-1:0]  sw_cand;
    logic [CNT_WIDTH-1:0] sw_cnt;

    // One counter for the whole vector: any bit change restarts the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            sw_cand <= '0;
            sw_cnt  <= '0;
            switch  <= '0;
        end else begin
            sw_s1 <= sw_raw;
            sw_s2 <= sw_s1;
            if (sw_s2 == switch) begin
                sw_cnt <= '0;
            end else if (sw_s2 == sw_cand) begin
                if (sw_cnt == CNT_MAX) begin
                    switch <= sw_cand;
                    sw_cnt <= '0;
                end else begin
                    sw_cnt <= sw_cnt + CNT_ONE;
                end
            end else begin
                sw_cand <= sw_s2;
                sw_cnt  <= CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4 (5-edge latency).
module tb_input_conditioner;

    logic        clk = 1'b0;
    logic        reset;
    logic        btnL_raw;
    logic        btnR_raw;
    logic [15:0] sw_raw;
    logic        buttonL;
    logic        buttonR;
    logic        btnL_level;
    logic        btnR_level;
    logic [15:0] switch;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .SW_WIDTH        (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btnL_raw   (btnL_raw),
        .btnR_raw   (btnR_raw),
        .sw_raw     (sw_raw),
        .buttonL    (buttonL),
        .buttonR    (buttonR),
        .btnL_level (btnL_level),
        .btnR_level (btnR_level),
        .switch     (switch)
    );

    typedef struct {
        logic        rst;
        logic        bl;
        logic        br;
        logic [15:0] sw;
        logic        pl;
        logic        pr;
        logic        ll;
        logic        lr;
        logic [15:0] esw;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic rst, logic bl, logic br, logic [15:0] sw,
                                logic pl, logic pr, logic ll, logic lr, logic [15:0] esw);
        vec_t v;
        v.rst = rst; v.bl = bl; v.br = br; v.sw = sw;
        v.pl = pl; v.pr = pr; v.ll = ll; v.lr = lr; v.esw = esw;
        return v;
    endfunction

    task automatic chk(input string name, input int unsigned t,
                       input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (t=%0d): got %h expected %h", name, t, act, exp);
        end
    endtask

    // Advance one edge and settle; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Each row is driven ahead of one edge; expectations are the outputs after it.
        vecs[0]  = mk(1, 1, 1, 16'hFFFF, 0, 0, 0, 0, 16'h0000);
        vecs[1]  = mk(1, 1, 1, 16'hFFFF, 0, 0, 0, 0, 16'h0000);
        vecs[2]  = mk(1, 1, 1, 16'hFFFF, 0, 0, 0, 0, 16'h0000);
        vecs[3]  = mk(0, 1, 1, 16'hFFFF, 0, 0, 0, 0, 16'h0000);
        vecs[4]  = mk(0, 1, 1, 16'hFFFF, 0, 0, 0, 0, 16'h0000);
        vecs[5]  = mk(0, 1, 1, 16'hFFFF, 0, 0, 0, 0, 16'h0000);
        vecs[6]  = mk(0, 1, 1, 16'hFFFF, 0, 0, 0, 0, 16'h0000);
        vecs[7]  = mk(0, 1, 1, 16'hFFFF, 0, 0, 0, 0, 16'h0000);
        vecs[8]  = mk(0, 1, 1, 16'hFFFF, 1, 1, 1, 1, 16'hFFFF);
        vecs[9]  = mk(0, 1, 1, 16'hFFFF, 0, 0, 1, 1, 16'hFFFF);
        vecs[10] = mk(0, 0, 0, 16'h0000, 0, 0, 1, 1, 16'hFFFF);
        vecs[11] = mk(0, 0, 0, 16'h0000, 0, 0, 1, 1, 16'hFFFF);
        vecs[12] = mk(0, 0, 0, 16'h0000, 0, 0, 1, 1, 16'hFFFF);
        vecs[13] = mk(0, 0, 0, 16'h0000, 0, 0, 1, 1, 16'hFFFF);
        vecs[14] = mk(0, 0, 0, 16'h0000, 0, 0, 1, 1, 16'hFFFF);
        vecs[15] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
        vecs[16] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
        vecs[17] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);

        for (int i = 0; i < 18; i++) begin
            reset    = vecs[i].rst;
            btnL_raw = vecs[i].bl;
            btnR_raw = vecs[i].br;
            sw_raw   = vecs[i].sw;
            tick();
            chk("tbl_buttonL", i, 16'(buttonL),    16'(vecs[i].pl));
            chk("tbl_buttonR", i, 16'(buttonR),    16'(vecs[i].pr));
            chk("tbl_levelL",  i, 16'(btnL_level), 16'(vecs[i].ll));
            chk("tbl_levelR",  i, 16'(btnR_level), 16'(vecs[i].lr));
            chk("tbl_switch",  i, switch,          vecs[i].esw);
        end

        // Left press held 20 cycles, then released.
        btnL_raw = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            chk("L_pulse", t, 16'(buttonL),    16'(t == 5));
            chk("L_level", t, 16'(btnL_level), 16'(t >= 5));
            chk("L_noR",   t, 16'(buttonR),    16'h0);
        end
        btnL_raw = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            chk("L_rel_level", t, 16'(btnL_level), 16'(t < 5));
            chk("L_rel_pulse", t, 16'(buttonL),    16'h0);
        end

        // Right button bounces; final rising sample is at t=5.
        for (int t = 0; t < 16; t++) begin
            case (t)
                0, 2, 3, 5: btnR_raw = 1'b1;
                1, 4:       btnR_raw = 1'b0;
                default:    btnR_raw = 1'b1;
            endcase
            tick();
            chk("R_bounce_pulse", t, 16'(buttonR),    16'(t == 10));
            chk("R_bounce_level", t, 16'(btnR_level), 16'(t >= 10));
            chk("R_bounce_noL",   t, 16'(buttonL),    16'h0);
        end
        btnR_raw = 1'b0;
        for (int t = 0; t < 8; t++) tick();
        chk("R_released", 0, 16'(btnR_level), 16'h0);

        // Simultaneous presses.
        btnL_raw = 1'b1;
        btnR_raw = 1'b1;
        for (int t = 0; t < 9; t++) begin
            tick();
            chk("both_L", t, 16'(buttonL), 16'(t == 5));
            chk("both_R", t, 16'(buttonR), 16'(t == 5));
        end
        btnL_raw = 1'b0;
        btnR_raw = 1'b0;
        for (int t = 0; t < 8; t++) tick();
        chk("both_releasedL", 0, 16'(btnL_level), 16'h0);
        chk("both_releasedR", 0, 16'(btnR_level), 16'h0);

        // Switch update then a short glitch that must be rejected.
        sw_raw = 16'hA5C3;
        for (int t = 0; t < 8; t++) begin
            tick();
            chk("sw_update", t, switch, (t >= 5) ? 16'hA5C3 : 16'h0000);
        end
        sw_raw = 16'hA5C2;
        tick();
        chk("sw_glitch", 0, switch, 16'hA5C3);
        tick();
        chk("sw_glitch", 1, switch, 16'hA5C3);
        sw_raw = 16'hA5C3;
        for (int t = 2; t < 12; t++) begin
            tick();
            chk("sw_glitch", t, switch, 16'hA5C3);
        end

        // Reset lands while left is in DEB_PRESS with cnt=2; sampling restarts at t=5.
        btnL_raw = 1'b1;
        for (int t = 0; t < 15; t++) begin
            reset = (t == 4);
            tick();
            chk("rst_mid_pulse", t, 16'(buttonL), 16'(t == 10));
            chk("rst_mid_level", t, 16'(btnL_level), 16'(t >= 10));
            chk("rst_mid_switch", t, switch,
                (t < 4) ? 16'hA5C3 : ((t >= 10) ? 16'hA5C3 : 16'h0000));
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Sits directly upstream of the memory-mapped IO peripheral.
- Takes the raw board pushbuttons (left/right) and the 16 slide switches, synchronises and debounces them.
- Delivers clean one-cycle button pulses plus a stable switch vector. These feed the IO block's buttonL/buttonR/switch inputs.
- Removes metastability and contact bounce so the IO block latches switches and LEDs exactly once per press.

Parameters:
- DEBOUNCE_CYCLES, 100000, number of consecutive identical synchronised samples required to accept a new level (1 ms at 100 MHz); legal range >= 2.
- SW_WIDTH, 16, number of switch inputs.
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES), width of every debounce counter (derived, not overridden).

Ports:
- clk  input  1  system clock; only clock in the block.
- reset  input  1  synchronous, active-high reset.
- btnL_raw  input  1  asynchronous raw left pushbutton.
- btnR_raw  input  1  asynchronous raw right pushbutton.
- sw_raw  input  SW_WIDTH  asynchronous raw slide switches.
- buttonL  output  1  one-cycle pulse per accepted left press.
- buttonR  output  1  one-cycle pulse per accepted right press.
- btnL_level  output  1  debounced left button level.
- btnR_level  output  1  debounced right button level.
- switch  output  SW_WIDTH  debounced, stable switch vector.

Behaviour:
- Reset: all outputs 0, all sync flops 0, counters 0, button FSMs in IDLE, switch register 0. Reset wins over every other event in the same cycle.
- Synchronisers: every raw input passes through a 2-flop synchroniser (s1 <= raw, s2 <= s1). All logic below uses s2 only.
- Button FSM, per button, states IDLE, DEB_PRESS, HELD, DEB_RELEASE; cnt is CNT_WIDTH bits:
  - IDLE: s2==1 -> DEB_PRESS, cnt <= 1.
  - DEB_PRESS:
    - s2==0 -> IDLE, cnt <= 0 (bounce rejected, no pulse).
    - s2==1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, pulse register <= 1.
    - else cnt++.
  - HELD: level=1. s2==0 -> DEB_RELEASE, cnt <= 1.
  - DEB_RELEASE:
    - s2==1 -> HELD, cnt <= 0.
    - s2==0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
    - else cnt++.
- Button outputs:
  - Pulse (buttonL/buttonR) is registered and high exactly one cycle, the cycle after entering HELD. It is never high in two consecutive cycles.
  - Level output = 1 in HELD and DEB_RELEASE, 0 in IDLE and DEB_PRESS.
- Button latency: raw first sampled high at edge k and held -> pulse visible after edge k+DEBOUNCE_CYCLES+1. Release: level falls after edge k'+DEBOUNCE_CYCLES+1. A release produces no pulse.
- Switch debouncer (one counter for the whole vector):
  - s2_sw == switch -> cnt <= 0.
  - s2_sw != switch:
    - If s2_sw == candidate: cnt++; when cnt reaches DEBOUNCE_CYCLES-1, switch <= candidate and cnt <= 0.
    - If s2_sw != candidate: candidate <= s2_sw, cnt <= 1.
  - Any change of any bit restarts the count. Same N+1-edge latency as the buttons.
- Independence: left, right and switch channels never interact. Simultaneous presses give simultaneous pulses.
- Counter wrap: cnt never exceeds DEBOUNCE_CYCLES-1, so no wrap-around occurs.
- Reset mid-debounce: progress is discarded. A button still held when reset deasserts is re-debounced from IDLE and produces one pulse after N+1 edges.
- No combinational path from any raw input to any output.

Decomposition:
- Shared package io_pkg holds:
  - btn_state_t enum {IDLE, DEB_PRESS, HELD, DEB_RELEASE}.
  - Constants DEBOUNCE_DEFAULT=100000 and SW_WIDTH_DEFAULT=16.
- Sub-module btn_debounce holds one button's synchroniser + FSM + pulse register. It is instantiated twice (left, right).
- Switch debouncer stays in the top.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset held 3 cycles with all raw inputs high -> all outputs 0 during reset. After release, buttonL and buttonR each pulse once, 5 edges later, and switch=16'hFFFF after 5 edges.
- btnL_raw high for 20 cycles then low -> buttonL high exactly one cycle, 5 edges after the first high sample. btnL_level high from that cycle until 5 edges after release. buttonR stays 0.
- btnR_raw bounces 1,0,1,1,0,1 (one value per cycle) then stays high -> no pulse during bounce, exactly one pulse 5 edges after the final rising sample.
- Both raw buttons rise on the same edge -> buttonL and buttonR pulse in the same cycle, each once.
- sw_raw 16'h0000 -> 16'hA5C3 -> switch updates to 16'hA5C3 after 5 edges. Then sw_raw glitches to 16'hA5C2 for 2 cycles and back -> switch stays 16'hA5C3.
- Reset asserted for 1 cycle while btnL in DEB_PRESS (cnt=2), raw still high -> no pulse in that cycle. After reset, exactly one pulse 5 edges later.
